octopos_mailbox_fifo_n: RTL and testbench
=========================================

OCTOPOS_MAILBOX_FIFO_N -- requirements
Module: octopos_mailbox_fifo_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, message word width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter N_CH, default 3, number of delegable reader channels.
REQ-004 SHALL have parameter QUOTA_W, default 8, quota counter width.
REQ-005 SHALL define derived widths OWNER_W=clog2(N_CH+1) and CNT_W=clog2(DEPTH+1); owner code N_CH = NONE.
REQ-006 SHALL have port clk, input, 1, sole clock; one clock, all logic on rising edge.
REQ-007 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have ports wr_valid, input, 1; wr_data, input, DATA_WIDTH; wr_ready, output, 1: fixed-side write.
REQ-009 SHALL have ports rd_valid, output, N_CH; rd_ready, input, N_CH; rd_data, output, DATA_WIDTH: per-channel read, shared data bus.
REQ-010 SHALL have ports deleg_valid, input, 1; deleg_owner, input, OWNER_W; deleg_quota, input, QUOTA_W: delegation command.
REQ-011 SHALL have port revoke, input, 1, forced return of ownership to NONE.
REQ-012 SHALL have ports deleg_ack, output, 1; deleg_err, output, 1: one-cycle command result pulses.
REQ-013 SHALL have status outputs count (CNT_W), owner (OWNER_W), quota_left (QUOTA_W).
REQ-014 SHALL have outputs irq (N_CH, level) and irq_fixed (1, pulse).

Function
REQ-015 SHALL implement a DEPTH-entry FIFO; wr_ready = (count != DEPTH); push on wr_valid && wr_ready.
REQ-016 SHALL drive rd_valid[i] = (owner == i) && (count != 0); all other bits 0.
REQ-017 SHALL drive rd_data combinationally from the head entry when count != 0, else 0 (zero-latency read).
REQ-018 SHALL pop on rd_valid[i] && rd_ready[i]; rd_ready bits of non-owners ignored.
REQ-019 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-020 SHALL accept deleg_valid only when owner == NONE, deleg_owner < N_CH, deleg_quota != 0: next edge owner <= deleg_owner, quota_left <= deleg_quota, deleg_ack = 1 for one cycle.
REQ-021 SHALL otherwise reject deleg_valid: state unchanged, deleg_err = 1 for one cycle.
REQ-022 SHALL decrement quota_left by 1 per pop; on the pop taking quota_left 1->0, owner <= NONE at the same edge and irq_fixed = 1 for the following cycle.
REQ-023 SHALL on revoke set owner <= NONE, quota_left <= 0 at next edge, without irq_fixed; FIFO contents retained.
REQ-024 SHALL complete a pop that coincides with revoke (data consumed, then owner NONE).
REQ-025 SHALL give revoke priority over a same-cycle deleg_valid, which gets deleg_err.
REQ-026 SHALL drive irq[i] = rd_valid[i] (level, owner with pending data).
REQ-027 SHALL ignore wr_valid when full and never underflow when empty.

Reset
REQ-028 SHALL, when resetn = 0 at a clock edge, clear pointers, count = 0, owner = NONE, quota_left = 0, deleg_ack = deleg_err = irq_fixed = 0.
REQ-029 SHALL hold during reset: wr_ready = 1, rd_valid = 0, irq = 0, rd_data = 0; reset mid-transfer discards all entries.
REQ-030 SHALL NOT require memory array initialisation.

Verification
REQ-031 SHALL cover: push 0xA1,0xA2, delegate owner 1 quota 2, ch1 rd_ready=1 -> rd_data 0xA1 then 0xA2, irq_fixed pulse after second pop, owner = 3 (NONE).
REQ-032 SHALL cover: delegate owner 0 quota 5 while owner 2 active -> deleg_err pulse, owner stays 2; deleg_owner 3 or quota 0 -> deleg_err.
REQ-033 SHALL cover: 16 pushes -> count 16, wr_ready 0, 17th write ignored; then push+pop same cycle at count 8 -> count stays 8.
REQ-034 SHALL cover: owner 2, rd_ready[0]=1 with data -> no pop, count unchanged; irq = 3'b100.
REQ-035 SHALL cover: revoke same cycle as pop and a deleg_valid -> pop completes (count-1), owner NONE, deleg_err, no irq_fixed.
REQ-036 SHALL cover: resetn low for one edge with count 5, owner 1 -> count 0, owner NONE, rd_valid 0, quota_left 0.

Source files
------------

// File: rtl/octopos_mailbox_fifo_n.sv
// Mailbox FIFO with a fixed-side writer and one delegable reader channel at a time.
// Reader ownership is granted with a pop quota and returns to NONE on exhaustion or revoke.
module octopos_mailbox_fifo_n #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int N_CH       = 3,
    parameter  int QUOTA_W    = 8,
    localparam int OWNER_W    = $clog2(N_CH + 1),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [N_CH-1:0]       rd_valid,
    input  logic [N_CH-1:0]       rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  deleg_valid,
    input  logic [OWNER_W-1:0]    deleg_owner,
    input  logic [QUOTA_W-1:0]    deleg_quota,
    input  logic                  revoke,
    output logic                  deleg_ack,
    output logic                  deleg_err,
    output logic [CNT_W-1:0]      count,
    output logic [OWNER_W-1:0]    owner,
    output logic [QUOTA_W-1:0]    quota_left,
    output logic [N_CH-1:0]       irq,
    output logic                  irq_fixed
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [OWNER_W-1:0] OWNER_NONE = OWNER_W'(N_CH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [OWNER_W-1:0]    r_owner;
    logic [QUOTA_W-1:0]    r_quota;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_irq_fixed;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_deleg_ok;
    logic [N_CH-1:0]       w_rd_valid;

    always_comb begin
        w_full  = (r_count == CNT_W'(DEPTH));
        w_empty = (r_count == '0);
        w_push  = wr_valid && !w_full;
        w_rd_valid = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_rd_valid[i] = resetn && !w_empty && (r_owner == OWNER_W'(i));
        end
        // Only the owner's bit can be set, so stray rd_ready from others never pops.
        w_pop      = |(w_rd_valid & rd_ready);
        w_deleg_ok = deleg_valid && !revoke && (r_owner == OWNER_NONE)
                     && (deleg_owner < OWNER_W'(N_CH)) && (deleg_quota != '0);
    end

    always_ff @(posedge clk) begin
        if (w_push && resetn) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_owner     <= OWNER_NONE;
            r_quota     <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_irq_fixed <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ack       <= w_deleg_ok;
            r_err       <= deleg_valid && !w_deleg_ok;
            r_irq_fixed <= w_pop && (r_quota == QUOTA_W'(1)) && !revoke;
            // Revoke overrides both delegation and quota bookkeeping of a coincident pop.
            if (revoke) begin
                r_owner <= OWNER_NONE;
                r_quota <= '0;
            end else if (w_deleg_ok) begin
                r_owner <= deleg_owner;
                r_quota <= deleg_quota;
            end else if (w_pop) begin
                r_quota <= r_quota - 1'b1;
                if (r_quota == QUOTA_W'(1)) r_owner <= OWNER_NONE;
            end
        end
    end

    assign wr_ready   = !resetn || !w_full;
    assign rd_valid   = w_rd_valid;
    assign irq        = w_rd_valid;
    assign rd_data    = (resetn && !w_empty) ? r_mem[r_rd_ptr] : '0;
    assign deleg_ack  = r_ack;
    assign deleg_err  = r_err;
    assign irq_fixed  = r_irq_fixed;
    assign count      = r_count;
    assign owner      = r_owner;
    assign quota_left = r_quota;
endmodule

// File: tb/tb_octopos_mailbox_fifo_n.sv
// Directed self-checking bench for octopos_mailbox_fifo_n (default parameters).
module tb_octopos_mailbox_fifo_n;
    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [2:0]  rd_valid;
    logic [2:0]  rd_ready;
    logic [31:0] rd_data;
    logic        deleg_valid;
    logic [1:0]  deleg_owner;
    logic [7:0]  deleg_quota;
    logic        revoke;
    logic        deleg_ack;
    logic        deleg_err;
    logic [4:0]  count;
    logic [1:0]  owner;
    logic [7:0]  quota_left;
    logic [2:0]  irq;
    logic        irq_fixed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    octopos_mailbox_fifo_n #(
        .DATA_WIDTH(32),
        .DEPTH(16),
        .N_CH(3),
        .QUOTA_W(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .deleg_valid(deleg_valid), .deleg_owner(deleg_owner), .deleg_quota(deleg_quota),
        .revoke(revoke), .deleg_ack(deleg_ack), .deleg_err(deleg_err),
        .count(count), .owner(owner), .quota_left(quota_left),
        .irq(irq), .irq_fixed(irq_fixed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; wr_data = '0; rd_ready = '0;
        deleg_valid = 0; deleg_owner = '0; deleg_quota = '0; revoke = 0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    task automatic push(input logic [31:0] d);
        wr_valid = 1; wr_data = d;
        tick();
        wr_valid = 0;
    endtask

    task automatic delegate(input logic [1:0] o, input logic [7:0] q);
        deleg_valid = 1; deleg_owner = o; deleg_quota = q;
        tick();
        deleg_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        tick();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner got %0d exp 3", owner); end
        checks++; if (quota_left !== 8'd0) begin errors++; $display("FAIL reset_quota got %0d exp 0", quota_left); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        checks++; if ({rd_valid, irq} !== 6'b0) begin errors++; $display("FAIL reset_rdv_irq got %b exp 0", {rd_valid, irq}); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if ({deleg_ack, deleg_err, irq_fixed} !== 3'b0) begin errors++; $display("FAIL reset_pulses got %b exp 000", {deleg_ack, deleg_err, irq_fixed}); end
        resetn = 1;
    endtask

    task automatic test_quota_pop();
        do_reset();
        push(32'hA1);
        push(32'hA2);
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL qp_count2 got %0d exp 2", count); end
        delegate(2'd1, 8'd2);
        checks++; if (deleg_ack !== 1'b1 || owner !== 2'd1 || quota_left !== 8'd2) begin errors++; $display("FAIL qp_deleg got ack=%b own=%0d q=%0d exp 1/1/2", deleg_ack, owner, quota_left); end
        checks++; if (irq !== 3'b010 || rd_valid !== 3'b010) begin errors++; $display("FAIL qp_irq got irq=%b rdv=%b exp 010", irq, rd_valid); end
        rd_ready = 3'b010;
        checks++; if (rd_data !== 32'hA1) begin errors++; $display("FAIL qp_data1 got %h exp a1", rd_data); end
        tick();
        checks++; if (rd_data !== 32'hA2 || quota_left !== 8'd1 || deleg_ack !== 1'b0) begin errors++; $display("FAIL qp_data2 got d=%h q=%0d ack=%b exp a2/1/0", rd_data, quota_left, deleg_ack); end
        tick();
        rd_ready = '0;
        checks++; if (owner !== 2'd3 || irq_fixed !== 1'b1 || count !== 5'd0 || quota_left !== 8'd0) begin errors++; $display("FAIL qp_done got own=%0d irqf=%b cnt=%0d q=%0d exp 3/1/0/0", owner, irq_fixed, count, quota_left); end
        checks++; if (rd_data !== 32'd0 || irq !== 3'b000) begin errors++; $display("FAIL qp_empty got d=%h irq=%b exp 0/000", rd_data, irq); end
        tick();
        checks++; if (irq_fixed !== 1'b0) begin errors++; $display("FAIL qp_irqf_pulse got %b exp 0", irq_fixed); end
    endtask

    task automatic test_deleg_err();
        do_reset();
        push(32'h11);
        delegate(2'd2, 8'd4);
        delegate(2'd0, 8'd5);
        checks++; if (deleg_err !== 1'b1 || deleg_ack !== 1'b0 || owner !== 2'd2 || quota_left !== 8'd4) begin errors++; $display("FAIL de_busy got err=%b ack=%b own=%0d q=%0d exp 1/0/2/4", deleg_err, deleg_ack, owner, quota_left); end
        revoke = 1; tick(); revoke = 0;
        checks++; if (owner !== 2'd3 || irq_fixed !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL de_revoke got own=%0d irqf=%b cnt=%0d exp 3/0/1", owner, irq_fixed, count); end
        delegate(2'd3, 8'd1);
        checks++; if (deleg_err !== 1'b1 || owner !== 2'd3) begin errors++; $display("FAIL de_badowner got err=%b own=%0d exp 1/3", deleg_err, owner); end
        delegate(2'd0, 8'd0);
        checks++; if (deleg_err !== 1'b1 || owner !== 2'd3 || quota_left !== 8'd0) begin errors++; $display("FAIL de_zeroq got err=%b own=%0d q=%0d exp 1/3/0", deleg_err, owner, quota_left); end
        tick();
        checks++; if (deleg_err !== 1'b0) begin errors++; $display("FAIL de_err_pulse got %b exp 0", deleg_err); end
    endtask

    task automatic test_full_and_concurrent();
        do_reset();
        for (int i = 0; i < 16; i++) push(32'(i));
        checks++; if (count !== 5'd16 || wr_ready !== 1'b0) begin errors++; $display("FAIL full got cnt=%0d wrr=%b exp 16/0", count, wr_ready); end
        push(32'hFF);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_ignore got %0d exp 16", count); end
        delegate(2'd0, 8'd12);
        rd_ready = 3'b001;
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL full_head got %h exp 0", rd_data); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (count !== 5'd8 || rd_data !== 32'd8 || quota_left !== 8'd4) begin errors++; $display("FAIL drain8 got cnt=%0d d=%h q=%0d exp 8/8/4", count, rd_data, quota_left); end
        wr_valid = 1; wr_data = 32'h55;
        tick();
        wr_valid = 0; rd_ready = '0;
        checks++; if (count !== 5'd8 || rd_data !== 32'd9 || quota_left !== 8'd3) begin errors++; $display("FAIL pushpop got cnt=%0d d=%h q=%0d exp 8/9/3", count, rd_data, quota_left); end
    endtask

    task automatic test_nonowner_and_revoke();
        do_reset();
        push(32'h11);
        delegate(2'd2, 8'd3);
        rd_ready = 3'b001;
        checks++; if (irq !== 3'b100 || rd_valid !== 3'b100) begin errors++; $display("FAIL no_irq got irq=%b rdv=%b exp 100", irq, rd_valid); end
        tick();
        checks++; if (count !== 5'd1 || quota_left !== 8'd3) begin errors++; $display("FAIL no_pop got cnt=%0d q=%0d exp 1/3", count, quota_left); end
        rd_ready = '0;
        push(32'h77);
        rd_ready = 3'b100; revoke = 1;
        deleg_valid = 1; deleg_owner = 2'd0; deleg_quota = 8'd1;
        tick();
        idle();
        checks++; if (count !== 5'd1 || owner !== 2'd3 || quota_left !== 8'd0) begin errors++; $display("FAIL rv_state got cnt=%0d own=%0d q=%0d exp 1/3/0", count, owner, quota_left); end
        checks++; if (deleg_err !== 1'b1 || deleg_ack !== 1'b0 || irq_fixed !== 1'b0) begin errors++; $display("FAIL rv_pulses got err=%b ack=%b irqf=%b exp 1/0/0", deleg_err, deleg_ack, irq_fixed); end
        checks++; if (rd_data !== 32'h77) begin errors++; $display("FAIL rv_head got %h exp 77", rd_data); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h30 + 32'(i));
        delegate(2'd1, 8'd3);
        checks++; if (count !== 5'd5 || owner !== 2'd1) begin errors++; $display("FAIL rm_pre got cnt=%0d own=%0d exp 5/1", count, owner); end
        resetn = 0;
        #1;
        checks++; if (rd_valid !== 3'b000 || wr_ready !== 1'b1 || rd_data !== 32'd0) begin errors++; $display("FAIL rm_hold got rdv=%b wrr=%b d=%h exp 000/1/0", rd_valid, wr_ready, rd_data); end
        tick();
        resetn = 1;
        checks++; if (count !== 5'd0 || owner !== 2'd3 || rd_valid !== 3'b000 || quota_left !== 8'd0) begin errors++; $display("FAIL rm_post got cnt=%0d own=%0d rdv=%b q=%0d exp 0/3/000/0", count, owner, rd_valid, quota_left); end
    endtask

    initial begin
        idle();
        resetn = 0;
        test_reset();
        test_quota_pop();
        test_deleg_err();
        test_full_and_concurrent();
        test_nonowner_and_revoke();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
